// File: rtl/rd_ps_ddr3_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rd_ps_ddr3_pkg
// Description : Shared definitions for the PS DDR MM2S read path. Holds the
//               DataMover command field layout, the fixed TYPE/EOF bits, the
//               read FSM state encoding and a command builder.
// Revision    : 1.0  initial release
// ============================================================================
package rd_ps_ddr3_pkg;

  // MM2S command word layout (72 bits):
  //   [71:64] reserved/tag, [63:32] address, [31] DRR, [30] EOF,
  //   [29:24] DSA, [23] TYPE, [22:0] BTT
  localparam int c_cmd_w    = 72;
  localparam int c_btt_lsb  = 0;
  localparam int c_btt_w    = 23;
  localparam int c_type_bit = 23;
  localparam int c_eof_bit  = 30;
  localparam int c_addr_lsb = 32;
  localparam int c_addr_w   = 32;

  localparam logic c_w_type = 1'b1;  // INCR burst
  localparam logic c_eof    = 1'b1;

  localparam int c_nbeat_w = 20;     // length[22:3]
  localparam int c_beat_w  = 64;
  localparam int c_word_w  = 32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CMD   = 3'd1,
    ST_DATA  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic logic [c_cmd_w-1:0] build_cmd(
    input logic [c_addr_w-1:0]  addr,
    input logic [c_nbeat_w-1:0] nbeats
  );
    logic [c_cmd_w-1:0] v_cmd;
    v_cmd                          = '0;
    v_cmd[c_addr_lsb +: c_addr_w]  = addr;
    v_cmd[c_eof_bit]               = c_eof;
    v_cmd[c_type_bit]              = c_w_type;
    v_cmd[c_btt_lsb +: c_btt_w]    = {nbeats, 3'b000};
    return v_cmd;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rd_ps_ddr3_dwc.sv
`default_nettype none
// ============================================================================
// Module      : rd_ps_ddr3_dwc
// Description : FIFO_DEPTH x 64-bit beat buffer followed by a 64->32 splitter.
//               The low half of the head beat is presented first, then the
//               high half; the beat is popped once its high half is taken.
// Ports       : clk/rst         clock, asynchronous active-high reset
//               i_push*         beat write (data + tlast flag)
//               o_full/o_empty  buffer status
//               i_ready         downstream accept
//               o_valid/o_data/o_last  32-bit output stream
// Revision    : 1.0  initial release
// ============================================================================
module rd_ps_ddr3_dwc
  import rd_ps_ddr3_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_push,
  input  logic [c_beat_w-1:0] i_push_data,
  input  logic                i_push_last,
  output logic                o_full,
  output logic                o_empty,
  input  logic                i_ready,
  output logic                o_valid,
  output logic [c_word_w-1:0] o_data,
  output logic                o_last
);

  localparam int             c_aw    = $clog2(FIFO_DEPTH);
  localparam logic [c_aw:0]  c_depth = (c_aw+1)'(FIFO_DEPTH);

  // Each entry carries the beat plus its tlast flag in the top bit.
  logic [c_beat_w:0] r_mem [FIFO_DEPTH];
  logic [c_aw-1:0]   r_wr_ptr;
  logic [c_aw-1:0]   r_rd_ptr;
  logic [c_aw:0]     r_count;
  logic              r_half;
  logic [c_beat_w:0] w_head;
  logic              w_xfer;
  logic              w_push;
  logic              w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == c_depth);
  assign o_valid = ~o_empty;
  assign w_head  = r_mem[r_rd_ptr];
  assign w_xfer  = o_valid & i_ready;
  assign w_pop   = w_xfer & r_half;
  // A push into a full buffer is only safe when the head leaves in the same cycle.
  assign w_push  = i_push & (~o_full | w_pop);

  // Data forced to zero while empty so the output never shows stale memory.
  assign o_data = o_valid ? (r_half ? w_head[63:32] : w_head[31:0]) : '0;
  assign o_last = o_valid & r_half & w_head[c_beat_w];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {i_push_last, i_push_data};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_half   <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_aw'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_aw'(1);
      end
      if (w_xfer) begin
        r_half <= ~r_half;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (c_aw+1)'(1);
        2'b01:   r_count <= r_count - (c_aw+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/rd_ps_ddr3.sv
`default_nettype none
// ============================================================================
// Module      : rd_ps_ddr3
// Description : Reads one block from PS DDR via the DataMover MM2S channel and
//               streams it to PL logic as 32-bit words, low half of each beat
//               first.
// Ports       : clk_ps/rst               clock, asynchronous active-high reset
//               ps_ddr_rd_start/addr/length   request (rising edge starts)
//               ps_ddr_rd_valid/ready/data/last  32-bit output stream
//               ps_ddr_rd_busy/done/err  status
//               m_axis_mm2s_cmd_*        72-bit DataMover command
//               m_axis_mm2s_*            64-bit read data from DataMover
// Revision    : 1.0  initial release
// ============================================================================
module rd_ps_ddr3
  import rd_ps_ddr3_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic               clk_ps,
  input  logic               rst,
  input  logic               ps_ddr_rd_start,
  input  logic [31:0]        ps_ddr_rd_addr,
  input  logic [31:0]        ps_ddr_rd_length,
  input  logic               ps_ddr_rd_ready,
  output logic               ps_ddr_rd_valid,
  output logic [31:0]        ps_ddr_rd_data,
  output logic               ps_ddr_rd_last,
  output logic               ps_ddr_rd_busy,
  output logic               ps_ddr_rd_done,
  output logic               ps_ddr_rd_err,
  input  logic               m_axis_mm2s_cmd_tready,
  output logic               m_axis_mm2s_cmd_tvalid,
  output logic [c_cmd_w-1:0] m_axis_mm2s_cmd_tdata,
  input  logic               m_axis_mm2s_tvalid,
  input  logic [63:0]        m_axis_mm2s_tdata,
  input  logic [7:0]         m_axis_mm2s_tkeep,
  input  logic               m_axis_mm2s_tlast,
  output logic               m_axis_mm2s_tready
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_catch;
  logic                 r_sync;
  logic                 w_rise;
  logic                 w_start_ok;
  logic [31:0]          r_addr;
  logic [c_nbeat_w-1:0] r_nbeats;
  logic [c_nbeat_w-1:0] r_beat_cnt;
  logic [c_nbeat_w-1:0] w_last_idx;
  logic                 r_err;
  logic                 w_beat_acc;
  logic                 w_full;
  logic                 w_empty;
  logic                 w_unused;

  // Full beats only; residual byte count below 8 is dropped.
  assign w_unused = ^{m_axis_mm2s_tkeep, ps_ddr_rd_length[31:23], ps_ddr_rd_length[2:0]};

  assign w_rise     = r_catch & ~r_sync;
  assign w_start_ok = w_rise & (r_state == ST_IDLE);
  assign w_last_idx = r_nbeats - c_nbeat_w'(1);

  assign m_axis_mm2s_tready = (r_state == ST_DATA) & ~w_full;
  assign w_beat_acc         = m_axis_mm2s_tvalid & m_axis_mm2s_tready;

  assign m_axis_mm2s_cmd_tdata = (r_state == ST_CMD) ? build_cmd(r_addr, r_nbeats) : '0;
  assign ps_ddr_rd_err         = r_err;

  always_ff @(posedge clk_ps or posedge rst) begin
    if (rst) begin
      r_catch <= 1'b0;
      r_sync  <= 1'b0;
    end else begin
      r_catch <= ps_ddr_rd_start;
      r_sync  <= r_catch;
    end
  end

  always_ff @(posedge clk_ps or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk_ps or posedge rst) begin
    if (rst) begin
      r_addr     <= '0;
      r_nbeats   <= '0;
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_start_ok) begin
      r_addr     <= ps_ddr_rd_addr;
      r_nbeats   <= ps_ddr_rd_length[22:3];
      r_beat_cnt <= '0;
      r_err      <= 1'b0;
    end else if (w_beat_acc) begin
      r_beat_cnt <= r_beat_cnt + c_nbeat_w'(1);
      // tlast must coincide exactly with the final expected beat; either an
      // early tlast or a missing one on beat N-1 flags the mismatch.
      if (m_axis_mm2s_tlast != (r_beat_cnt == w_last_idx)) begin
        r_err <= 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt            = r_state;
    ps_ddr_rd_busy         = 1'b0;
    ps_ddr_rd_done         = 1'b0;
    m_axis_mm2s_cmd_tvalid = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_rise) begin
          w_state_nxt = (ps_ddr_rd_length[22:3] == '0) ? ST_DONE : ST_CMD;
        end
      end
      ST_CMD: begin
        ps_ddr_rd_busy         = 1'b1;
        m_axis_mm2s_cmd_tvalid = 1'b1;
        if (m_axis_mm2s_cmd_tready) begin
          w_state_nxt = ST_DATA;
        end
      end
      ST_DATA: begin
        ps_ddr_rd_busy = 1'b1;
        if (w_beat_acc && m_axis_mm2s_tlast) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        ps_ddr_rd_busy = 1'b1;
        // Buffer empties only when the high half of the last beat is taken.
        if (w_empty) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        ps_ddr_rd_busy = 1'b1;
        ps_ddr_rd_done = 1'b1;
        w_state_nxt    = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  rd_ps_ddr3_dwc #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_dwc (
    .clk         (clk_ps),
    .rst         (rst),
    .i_push      (w_beat_acc),
    .i_push_data (m_axis_mm2s_tdata),
    .i_push_last (m_axis_mm2s_tlast),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .i_ready     (ps_ddr_rd_ready),
    .o_valid     (ps_ddr_rd_valid),
    .o_data      (ps_ddr_rd_data),
    .o_last      (ps_ddr_rd_last)
  );

endmodule
`default_nettype wire
